// File: rtl/apb_pkg.sv
// Shared encodings for the APB read/write/read-modify-write master.
package apb_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;
    localparam logic [1:0] OP_RMW   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    // RMW progress: read phase first, then the write-back phase.
    typedef enum logic {
        PH_RD,
        PH_WR
    } phase_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter; only built when APB_TIMEOUT_EN is defined.
// expired fires on the wait cycle that brings the count to TIMEOUT_CYC.
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign expired = inc && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_rmw_master.sv
// APB3 single-slave master: READ, WRITE and atomic READ-MODIFY-WRITE.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait states.
module apb_rmw_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("apb_rmw_master: TIMEOUT_CYC must be >= 1");
    end

    state_t            state;
    phase_t            phase;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] addend_q;
    logic [DATA_W-1:0] orig_q;
    logic              tmo;
    logic              rmw_rd;
    logic              done;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clr      (state == ST_SETUP),
        .inc      ((state == ST_ACCESS) && !pready),
        .expired  (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    assign cmd_ready = (state == ST_IDLE);
    assign rmw_rd    = (op_q == OP_RMW) && (phase == PH_RD);
    // Every ACCESS exit ends the command except a clean RMW read phase.
    assign done      = (state == ST_ACCESS) && (pready ? !(rmw_rd && !pslverr) : tmo);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= ST_IDLE;
            phase     <= PH_RD;
            op_q      <= OP_NOP;
            addend_q  <= '0;
            orig_q    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_op != OP_NOP) begin
                        op_q     <= cmd_op;
                        addend_q <= cmd_wdata;
                        phase    <= PH_RD;
                        state    <= ST_SETUP;
                        psel     <= 1'b1;
                        paddr    <= cmd_addr;
                        pwrite   <= (cmd_op == OP_WRITE);
                        pwdata   <= (cmd_op == OP_WRITE) ? cmd_wdata : '0;
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        pwrite    <= 1'b0;
                        paddr     <= '0;
                        pwdata    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !pready || pslverr;
                        if (!pready)
                            rsp_rdata <= (op_q == OP_RMW && phase == PH_WR) ? orig_q : '0;
                        else if (op_q == OP_READ || rmw_rd)
                            rsp_rdata <= prdata;
                        else if (op_q == OP_RMW)
                            rsp_rdata <= orig_q;
                        else
                            rsp_rdata <= '0;
                    end else if (pready) begin
                        // Back-to-back write phase: psel held, penable drops for SETUP.
                        orig_q  <= prdata;
                        pwdata  <= prdata + addend_q;
                        pwrite  <= 1'b1;
                        penable <= 1'b0;
                        phase   <= PH_WR;
                        state   <= ST_SETUP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rmw_master.sv
// Scoreboard bench for apb_rmw_master: scripted APB slave plus a
// memory-level reference model of READ / WRITE / RMW outcomes.
module tb_apb_rmw_master;

    localparam int TMO = 4;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    apb_rmw_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int unsigned cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // One APB phase the slave will see: expected bus values and scripted reply.
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic bit is_to(int w);
`ifdef APB_TIMEOUT_EN
        return w >= TMO;
`else
        return (w < 0);
`endif
    endfunction

    // Issue one command; the model decides its full outcome at acceptance.
    task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] d,
                         int w1, logic e1, int w2, logic e2);
        int n;
        exp_t r;
        logic [31:0] orig, nv;
        n = 0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 500) begin @(negedge pclk); n++; end
        if (!cmd_ready) begin
            chk("cmd_ready_wait", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        r.rdata = '0; r.err = 1'b0; r.due = cyc;
        orig = mem_rd(a);
        nv = orig + d;
        if (op == 2'b01) begin
            plan_q.push_back('{a, 1'b0, 32'h0, w1, e1, orig});
            if (is_to(w1)) begin r.err = 1'b1; r.due = cyc + 2 + TMO; end
            else begin r.rdata = orig; r.err = e1; r.due = cyc + 3 + w1; end
        end else if (op == 2'b11) begin
            plan_q.push_back('{a, 1'b1, d, w1, e1, 32'h0});
            if (is_to(w1)) begin r.err = 1'b1; r.due = cyc + 2 + TMO; end
            else begin
                if (!e1) mem[a] = d;
                r.err = e1; r.due = cyc + 3 + w1;
            end
        end else if (op == 2'b10) begin
            plan_q.push_back('{a, 1'b0, 32'h0, w1, e1, orig});
            if (is_to(w1)) begin r.err = 1'b1; r.due = cyc + 2 + TMO; end
            else if (e1) begin r.rdata = orig; r.err = 1'b1; r.due = cyc + 3 + w1; end
            else begin
                plan_q.push_back('{a, 1'b1, nv, w2, e2, 32'h0});
                r.rdata = orig;
                if (is_to(w2)) begin r.err = 1'b1; r.due = cyc + 4 + w1 + TMO; end
                else begin
                    if (!e2) mem[a] = nv;
                    r.err = e2; r.due = cyc + 5 + w1 + w2;
                end
            end
        end
        if (op != 2'b00) exp_q.push_back(r);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    // Response monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (preset_n && rsp_valid) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.due);
                    chk("ready_in_rsp", cmd_ready, 1);
                end
            end
        end
    end

    // Scripted slave: plays plan_q, checks bus values, drives noise elsewhere.
    initial begin : slave
        plan_t cur;
        bit in_acc;
        int n;
        logic [31:0] sa, sd;
        logic sw;
        in_acc = 0; n = 0; sa = '0; sd = '0; sw = 1'b0;
        cur = '{32'h0, 1'b0, 32'h0, 0, 1'b0, 32'h0};
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                in_acc = 0; pready = 1'b0; pslverr = 1'b0;
            end else if (psel && penable) begin
                if (!in_acc) begin
                    in_acc = 1; n = 0; sa = paddr; sw = pwrite; sd = pwdata;
                    if (plan_q.size() == 0) begin
                        chk("unexpected_access", 1, 0);
                        cur = '{paddr, pwrite, pwdata, 0, 1'b0, 32'h0};
                    end else begin
                        cur = plan_q.pop_front();
                        chk("paddr", paddr, cur.addr);
                        chk("pwrite", pwrite, cur.wr);
                        chk("pwdata", pwdata, cur.wdata);
                    end
                end else begin
                    n++;
                    chk("paddr_stable", paddr, sa);
                    chk("pwrite_stable", pwrite, sw);
                    chk("pwdata_stable", pwdata, sd);
                end
                if (n == cur.waits) begin
                    pready = 1'b1; pslverr = cur.err; prdata = cur.rdata;
                end else begin
                    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
                end
            end else begin
                in_acc = 0;
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
                if (!psel) begin
                    chk("idle_paddr", paddr, 0);
                    chk("idle_pwdata", pwdata, 0);
                    chk("idle_pwrite", pwrite, 0);
                end else if (plan_q.size() > 0) begin
                    chk("setup_paddr", paddr, plan_q[0].addr);
                    chk("setup_pwrite", pwrite, plan_q[0].wr);
                    chk("setup_pwdata", pwdata, plan_q[0].wdata);
                end
            end
        end
    end

    initial begin : main
        int n;
        logic [1:0] op;
        int wmax;
        repeat (3) @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        #2 preset_n = 1'b1;
        @(negedge pclk);
        chk("ready_after_rst", cmd_ready, 1);

        mem[32'h0000_A000] = 32'h1234_5678;
        issue(2'b01, 32'h0000_A000, 32'h0, 0, 1'b0, 0, 1'b0);
        issue(2'b11, 32'h10, 32'hDEAD_BEEF, 3, 1'b0, 0, 1'b0);
        mem[32'h0000_A000] = 32'hFFFF_FFFF;
        issue(2'b10, 32'h0000_A000, 32'h1, 0, 1'b0, 0, 1'b0);
        issue(2'b10, 32'h20, 32'h5, 1, 1'b1, 0, 1'b0);
        issue(2'b01, 32'h20, 32'h0, 0, 1'b0, 0, 1'b0);
        issue(2'b00, 32'h24, 32'h9, 0, 1'b0, 0, 1'b0);
        issue(2'b10, 32'h28, 32'h3, 2, 1'b0, 1, 1'b1);
        // Wait-limit boundary, long wait, and write-phase limit.
        issue(2'b01, 32'h34, 32'h0, TMO - 1, 1'b0, 0, 1'b0);
        issue(2'b01, 32'h30, 32'h0, 12, 1'b0, 0, 1'b0);
        issue(2'b10, 32'h38, 32'h7, 0, 1'b0, 12, 1'b0);
        issue(2'b11, 32'h3C, 32'h1111, 9, 1'b0, 0, 1'b0);

        // Reset in the middle of an ACCESS.
        issue(2'b01, 32'h40, 32'h0, 6, 1'b0, 0, 1'b0);
        n = 0;
        while (!(psel && penable) && n < 20) begin @(negedge pclk); n++; end
        chk("reached_access", psel && penable, 1);
        @(negedge pclk);
        #2 preset_n = 1'b0;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        plan_q.delete();
        @(negedge pclk);
        #2 preset_n = 1'b1;
        repeat (10) @(negedge pclk);
        chk("ready_after_midrst", cmd_ready, 1);

`ifdef APB_TIMEOUT_EN
        wmax = TMO + 1;
`else
        wmax = 5;
`endif
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            issue(op, 32'($urandom_range(0, 7)) * 4, $urandom,
                  $urandom_range(0, wmax), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, wmax), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge pclk);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin @(negedge pclk); n++; end
        chk("drain_rsp", exp_q.size(), 0);
        chk("drain_phases", plan_q.size(), 0);
        repeat (3) @(negedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
